// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side checker for the VGA sync pair. It measures the line period,
//   the hsync pulse width and the lines per frame. It declares lock after
//   LOCK_FRAMES consecutive in-spec frames, and flags out-of-spec timing while
//   locked.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   vga_h_sync   horizontal sync under test (asynchronous to clk)
//   vga_v_sync   vertical sync under test (asynchronous to clk)
//   locked       timing has been in spec for LOCK_FRAMES frames
//   line_len     last measured line period, clk cycles
//   hs_width     last measured hsync active width, clk cycles
//   frame_lines  last measured lines per frame
//   frame_tick   1-clk pulse per vsync leading edge
//   err          1-clk pulse per error while locked, or on a timeout
//   err_cnt      saturating error count
module vga_sync_monitor #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int EXP_LINE_CLKS   = 1600,
    parameter int EXP_FRAME_LINES = 512,
    parameter int TOL             = 2,
    parameter int LOCK_FRAMES     = 2,
    parameter int TIMEOUT_CLKS    = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [11:0] hs_width,
    output logic [10:0] frame_lines,
    output logic        frame_tick,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [12:0] LINE_MAX  = 13'(EXP_LINE_CLKS + TOL);
    localparam logic [12:0] LINE_MIN  = 13'(EXP_LINE_CLKS - TOL);
    localparam logic [10:0] FRAME_EXP = 11'(EXP_FRAME_LINES);
    localparam logic [11:0] TO_CLKS   = 12'(TIMEOUT_CLKS);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nxt;

    // The synchroniser flops hold polarity-normalised values (1 = active).
    // Reset to 0 therefore means "inactive", and no false edge follows reset.
    logic h_meta, h_act, h_prev, hs_start;
    logic v_meta, v_act, v_prev, vs_start;

    logic [11:0] h_cnt, hw_cnt;
    logic [10:0] v_cnt;
    logic [12:0] period;
    logic [3:0]  good_cnt, good_nxt;
    logic        line_valid, line_bad;
    logic        line_fail, frame_fail, timeout, err_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_meta   <= 1'b0;
            h_act    <= 1'b0;
            h_prev   <= 1'b0;
            hs_start <= 1'b0;
            v_meta   <= 1'b0;
            v_act    <= 1'b0;
            v_prev   <= 1'b0;
            vs_start <= 1'b0;
        end else begin
            h_meta   <= vga_h_sync ^ SYNC_ACTIVE_LOW;
            h_act    <= h_meta;
            h_prev   <= h_act;
            hs_start <= h_act & ~h_prev;
            v_meta   <= vga_v_sync ^ SYNC_ACTIVE_LOW;
            v_act    <= v_meta;
            v_prev   <= v_act;
            vs_start <= v_act & ~v_prev;
        end
    end

    // h_cnt is 0 in the cycle after hs_start. So on the next strobe h_cnt+1 is
    // the full period.
    assign period     = {1'b0, h_cnt} + 13'd1;
    assign line_fail  = hs_start && line_valid && (period > LINE_MAX || period < LINE_MIN);
    // line_bad only holds lines that ended before this strobe. A line that ends
    // on a coincident hs/vs strobe is booked to the new frame.
    assign frame_fail = (v_cnt != FRAME_EXP) || line_bad;
    assign timeout    = (state != SEARCH) && (h_cnt >= TO_CLKS);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_ev    = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_start) begin
                    state_nxt = MEASURE;
                    good_nxt  = 4'd0;
                end
            end
            MEASURE: begin
                if (vs_start) begin
                    if (frame_fail) begin
                        good_nxt = 4'd0;
                    end else begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_nxt == LOCK_N) state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_fail || (vs_start && frame_fail)) begin
                    err_ev    = 1'b1;
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        if (timeout) begin
            err_ev    = 1'b1;
            state_nxt = SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            good_cnt    <= 4'd0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= 8'd0;
            frame_tick  <= 1'b0;
            h_cnt       <= 12'd0;
            hw_cnt      <= 12'd0;
            v_cnt       <= 11'd0;
            line_len    <= 12'd0;
            hs_width    <= 12'd0;
            frame_lines <= 11'd0;
            line_valid  <= 1'b0;
            line_bad    <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_nxt;
            locked     <= (state_nxt == LOCKED);
            err        <= err_ev;
            frame_tick <= vs_start;
            if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            if (hs_start)             h_cnt <= 12'd0;
            else if (h_cnt != 12'hFFF) h_cnt <= h_cnt + 12'd1;

            if (hs_start && line_valid) line_len <= period[12] ? 12'hFFF : period[11:0];

            // Every fresh search starts without a reference edge, so the
            // first line is not checked.
            if (state_nxt == SEARCH && state != SEARCH) line_valid <= 1'b0;
            else if (hs_start)                          line_valid <= 1'b1;

            if (h_act) begin
                if (hw_cnt != 12'hFFF) hw_cnt <= hw_cnt + 12'd1;
            end else if (h_prev) begin
                hs_width <= hw_cnt;
                hw_cnt   <= 12'd0;
            end

            if (vs_start) begin
                frame_lines <= v_cnt;
                v_cnt       <= hs_start ? 11'd1 : 11'd0;
                line_bad    <= line_fail;
            end else begin
                if (hs_start && v_cnt != 11'h7FF) v_cnt <= v_cnt + 11'd1;
                if (line_fail) line_bad <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor
//   Bench for vga_sync_monitor with shortened timing so that whole frames
//   fit in a short run. An event-level model tracks the sync edges that the
//   bench drives. From those edges it derives the expected lock, error and
//   measurement values.
module tb_vga_sync_monitor;

    localparam bit SAL  = 1'b1;
    localparam int EXP  = 40;
    localparam int EFL  = 8;
    localparam int TOL  = 2;
    localparam int LOCK = 2;
    localparam int TO   = 100;

    logic        clk = 1'b0, rst = 1'b1;
    logic        vga_h_sync = 1'b1, vga_v_sync = 1'b1;
    logic        locked, frame_tick, err;
    logic [11:0] line_len, hs_width;
    logic [10:0] frame_lines;
    logic [7:0]  err_cnt;

    vga_sync_monitor #(
        .SYNC_ACTIVE_LOW(SAL), .EXP_LINE_CLKS(EXP), .EXP_FRAME_LINES(EFL),
        .TOL(TOL), .LOCK_FRAMES(LOCK), .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .rst(rst), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .locked(locked), .line_len(line_len), .hs_width(hs_width),
        .frame_lines(frame_lines), .frame_tick(frame_tick), .err(err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, n_err = 0, n_tick = 0, last_err_cyc = -1;
    int line_c0 = 0, prev_len = 0;

    // Reference model, at the level of sync edges.
    localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;
    int m_state, m_good, m_vcnt, m_lines, m_len, m_width, m_errs, m_ticks;
    bit m_lvalid, m_lbad;

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_state = M_SEARCH; m_good = 0; m_vcnt = 0; m_lines = 0; m_len = 0;
        m_width = 0; m_errs = 0; m_ticks = 0; m_lvalid = 0; m_lbad = 0;
    endfunction

    // An hsync and/or vsync leading edge. plen is the length of the line that
    // this hsync edge closes.
    function automatic void m_event(bit hs, bit vs, int plen);
        bit lfail, ffail;
        lfail = 0;
        ffail = 0;
        if (hs && m_lvalid) begin
            m_len = (plen > 4095) ? 4095 : plen;
            lfail = (plen > EXP + TOL) || (plen < EXP - TOL);
        end
        if (vs) begin
            ffail   = (m_vcnt != EFL) || m_lbad;
            m_lines = m_vcnt;
            m_vcnt  = hs ? 1 : 0;
            m_lbad  = lfail;
            m_ticks++;
        end else if (hs) begin
            m_vcnt++;
            if (lfail) m_lbad = 1;
        end
        if (hs) m_lvalid = 1;
        case (m_state)
            M_SEARCH:  if (vs) begin m_state = M_MEASURE; m_good = 0; end
            M_MEASURE: if (vs) begin
                if (ffail) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == LOCK) m_state = M_LOCKED;
                end
            end
            default: if (lfail || (vs && ffail)) begin
                m_errs++; m_state = M_SEARCH; m_lvalid = 0;
            end
        endcase
    endfunction

    function automatic void m_timeout();
        if (m_state != M_SEARCH) begin
            m_errs++; m_state = M_SEARCH; m_lvalid = 0;
        end
    endfunction

    // Advance one clock: sample the pulse outputs, then drive the pins.
    task automatic step(bit h, bit v);
        @(negedge clk);
        cyc++;
        if (err) begin n_err++; last_err_cyc = cyc; end
        if (frame_tick) n_tick++;
        vga_h_sync = h ^ SAL;
        vga_v_sync = v ^ SAL;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".line_len"}, int'(line_len), m_len);
        chk({tag, ".hs_width"}, int'(hs_width), m_width);
        chk({tag, ".frame_lines"}, int'(frame_lines), m_lines);
        chk({tag, ".locked"}, int'(locked), int'(m_state == M_LOCKED));
        chk({tag, ".err_cnt"}, int'(err_cnt), (m_errs > 255) ? 255 : m_errs);
        chk({tag, ".err_pulses"}, n_err, m_errs);
        chk({tag, ".ticks"}, n_tick, m_ticks);
    endtask

    // One line: an hsync leading edge, then len clocks. vs_at >= 0 puts a
    // 3-clk vsync pulse at that offset.
    task automatic drive_line(int len, int wid, int vs_at, string tag);
        m_event(1'b1, vs_at == 0, prev_len);
        for (int c = 0; c < len; c++) begin
            if (c == vs_at && vs_at > 0) m_event(1'b0, 1'b1, 0);
            step(c < wid, vs_at >= 0 && c >= vs_at && c < vs_at + 3);
            if (c == 0) line_c0 = cyc;
        end
        if (len > TO + 5) m_timeout();
        m_width  = wid;
        prev_len = len;
        check_all(tag);
    endtask

    task automatic frame(int off, string tag);
        for (int l = 0; l < EFL; l++) drive_line(EXP, 6, (l == 0) ? off : -1, tag);
    endtask

    task automatic rand_frame(int off);
        int len, wid;
        for (int l = 0; l < EFL; l++) begin
            len = EXP - TOL + int'($urandom_range(0, 2 * TOL));
            wid = int'($urandom_range(3, 12));
            if (l != 0 && $urandom_range(0, 39) == 0)
                len = ($urandom_range(0, 1) == 1) ? EXP + TOL + 1 + int'($urandom_range(0, 8))
                                                  : EXP - TOL - 1 - int'($urandom_range(0, 8));
            drive_line(len, wid, (l == 0) ? off : -1, "rand");
        end
    endtask

    initial begin
        int off;
        m_reset();

        // 1. reset held for 5 clocks
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("rst.locked", int'(locked), 0);
        chk("rst.line_len", int'(line_len), 0);
        chk("rst.hs_width", int'(hs_width), 0);
        chk("rst.frame_lines", int'(frame_lines), 0);
        chk("rst.frame_tick", int'(frame_tick), 0);
        chk("rst.err", int'(err), 0);
        chk("rst.err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        n_err = 0; n_tick = 0;

        // 2. nominal timing, lock after two complete frames
        drive_line(EXP, 6, -1, "pre");
        drive_line(EXP, 6, -1, "pre");
        frame(5, "nom");
        frame(5, "nom");
        chk("nom.unlocked_before_3rd_vs", int'(locked), 0);
        frame(5, "nom");
        chk("nom.locked", int'(locked), 1);
        chk("nom.line_len", int'(line_len), EXP);
        chk("nom.hs_width", int'(hs_width), 6);
        chk("nom.frame_lines", int'(frame_lines), EFL);

        // 3. one long line while locked, then relock; an edge-of-tolerance line
        drive_line(EXP, 6, 5, "t3");
        drive_line(EXP, 6, -1, "t3");
        drive_line(EXP + 10, 6, -1, "t3");
        drive_line(EXP, 6, -1, "t3");
        chk("t3.err_cycle", last_err_cyc, line_c0 + 4);
        chk("t3.err_cnt", int'(err_cnt), 1);
        chk("t3.locked", int'(locked), 0);
        for (int l = 4; l < EFL; l++) drive_line(EXP, 6, -1, "t3");
        frame(5, "t3"); frame(5, "t3"); frame(5, "t3");
        chk("t3.relocked", int'(locked), 1);
        drive_line(EXP, 6, 5, "t3b");
        drive_line(EXP + TOL, 6, -1, "t3b");
        for (int l = 2; l < EFL; l++) drive_line(EXP, 6, -1, "t3b");
        chk("t3b.err_cnt", int'(err_cnt), 1);
        chk("t3b.locked", int'(locked), 1);

        // 4. hsync stuck inactive while locked
        drive_line(TO + 30, 6, -1, "t4");
        chk("t4.err_cycle", last_err_cyc, line_c0 + TO + 5);
        chk("t4.locked", int'(locked), 0);
        chk("t4.line_len", int'(line_len), EXP);
        chk("t4.err_cnt", int'(err_cnt), 2);

        // 5. vsync and hsync leading edges in the same clock
        frame(0, "t5"); frame(0, "t5");
        chk("t5.frame_lines_a", int'(frame_lines), EFL);
        frame(0, "t5");
        chk("t5.frame_lines_b", int'(frame_lines), EFL);
        chk("t5.locked", int'(locked), 1);

        // randomized lines and frames
        off = 5;
        for (int f = 0; f < 30; f++) begin
            if (f % 6 == 0) off = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
            rand_frame(off);
        end

        // 6a. reset while locked
        for (int f = 0; f < 5; f++) frame(5, "t6");
        chk("t6.locked_before", int'(locked), 1);
        rst = 1'b1;
        step(1'b0, 1'b0);
        chk("t6.rst_locked", int'(locked), 0);
        chk("t6.rst_err_cnt", int'(err_cnt), 0);
        chk("t6.rst_line_len", int'(line_len), 0);
        rst = 1'b0;
        m_reset(); n_err = 0; n_tick = 0; prev_len = 0; m_width = 0;

        // 6b. 300 forced timeout errors, err_cnt saturates
        for (int i = 0; i < TO + 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            m_event(1'b0, 1'b1, 0);
            m_timeout();
            for (int c = 0; c < 8; c++) step(1'b0, c < 3);
            if (i == 199) check_all("sat200");
        end
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
        check_all("sat");
        chk("sat.err_cnt", int'(err_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
